// File: rtl/icache_fill_port.sv
// icache_fill_port
//   Services ICache miss requests. A 32-bit word read is broken into four
//   sequential byte reads on the byte-wide RAM bus. The bytes are assembled
//   little-endian, and the word is returned with a one-cycle valid pulse.
//
// Ports
//   clk_in         rising-edge clock
//   rst_in         asynchronous active-low reset
//   rdy_in         global ready; low freezes every register
//   clear          synchronous flush; aborts any request in progress
//   data_get_en    ICache miss request, held high until serviced
//   data_get_addr  byte address of the requested word
//   data_en_o      returned word valid (one-cycle pulse)
//   data_o         returned word
//   mem_grant      arbiter grants the RAM bus this cycle
//   mem_a          registered RAM byte address
//   mem_din        RAM read byte, valid one cycle after its address
//   if_busy        high whenever the port is not idle
module icache_fill_port #(
  parameter int ADDR_W = 32
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic              clear,
  input  logic              data_get_en,
  input  logic [31:0]       data_get_addr,
  output logic              data_en_o,
  output logic [31:0]       data_o,
  input  logic              mem_grant,
  output logic [ADDR_W-1:0] mem_a,
  input  logic [7:0]        mem_din,
  output logic              if_busy
);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DONE
  } state_t;

  state_t      state;
  logic [31:0] base;      // latched request address
  logic [2:0]  iss;       // bytes issued, 0..4
  logic [2:0]  rcv;       // bytes captured, 0..4
  logic        pend;      // an address was issued onto mem_a this cycle
  logic        cap;       // mem_din holds the byte for last cycle's address
  logic [31:0] asm_word;  // partially assembled word; data_o is only
                          // written once all four bytes are in

  // The RAM answers one cycle after it sees mem_a, so the capture strobe is
  // the issue strobe delayed by one cycle. This also makes a stalled grant
  // capture the last issued byte exactly once.

  // NOTE: state registers use non-blocking assignments so every register
  // samples the values from before the edge, independent of statement order.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state    <= IDLE;
      base     <= '0;
      iss      <= '0;
      rcv      <= '0;
      pend     <= 1'b0;
      cap      <= 1'b0;
      asm_word <= '0;
      mem_a    <= '0;
      data_o   <= '0;
    end else if (rdy_in) begin
      if (clear) begin
        // Abort: drop the in-flight byte; data_o keeps its last word.
        state <= IDLE;
        iss   <= '0;
        rcv   <= '0;
        pend  <= 1'b0;
        cap   <= 1'b0;
      end else begin
        cap <= pend;
        unique case (state)
          IDLE: begin
            if (data_get_en && mem_grant) begin
              state <= FETCH;
              base  <= data_get_addr;
              mem_a <= ADDR_W'(data_get_addr);
              iss   <= 3'd1;
              rcv   <= 3'd0;
              pend  <= 1'b1;
            end
          end

          FETCH: begin
            if (mem_grant && !iss[2]) begin
              mem_a <= ADDR_W'(base + 32'(iss));
              iss   <= iss + 3'd1;
              pend  <= 1'b1;
            end else begin
              pend  <= 1'b0;
            end

            if (cap) begin
              rcv <= rcv + 3'd1;
              if (rcv == 3'd3) begin
                data_o <= {mem_din, asm_word[23:0]};
                state  <= DONE;
              end else begin
                asm_word[8*rcv[1:0] +: 8] <= mem_din;
              end
            end
          end

          DONE: begin
            state <= IDLE;
            iss   <= '0;
            rcv   <= '0;
            pend  <= 1'b0;
          end

          default: state <= IDLE;
        endcase
      end
    end
  end

  assign data_en_o = (state == DONE) && !clear;
  assign if_busy   = (state != IDLE);

endmodule

// File: tb/tb_icache_fill_port.sv
// tb_icache_fill_port
//   Directed bench for icache_fill_port. A behavioural byte RAM answers one
//   cycle after each address and freezes with rdy_in. Every cycle is entered
//   1 time unit after the rising edge; inputs are driven there and outputs
//   are compared against hand-computed timelines.
module tb_icache_fill_port;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic        clear;
  logic        data_get_en;
  logic [31:0] data_get_addr;
  logic        data_en_o;
  logic [31:0] data_o;
  logic        mem_grant;
  logic [31:0] mem_a;
  logic [7:0]  mem_din;
  logic        if_busy;

  int vectors     = 0;
  int miscompares = 0;

  icache_fill_port #(.ADDR_W(32)) dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .rdy_in        (rdy_in),
    .clear         (clear),
    .data_get_en   (data_get_en),
    .data_get_addr (data_get_addr),
    .data_en_o     (data_en_o),
    .data_o        (data_o),
    .mem_grant     (mem_grant),
    .mem_a         (mem_a),
    .mem_din       (mem_din),
    .if_busy       (if_busy)
  );

  always #5 clk_in = ~clk_in;

  function automatic logic [7:0] ram_byte(input logic [31:0] a);
    case (a)
      32'h0000_0100: return 8'h13;
      32'h0000_0101: return 8'h05;
      32'h0000_0102: return 8'h10;
      32'h0000_0103: return 8'h00;
      32'h0000_0200: return 8'hAA;
      32'h0000_0201: return 8'hBB;
      32'h0000_0202: return 8'hCC;
      32'h0000_0203: return 8'hDD;
      32'hFFFF_FFFE: return 8'h11;
      32'hFFFF_FFFF: return 8'h22;
      32'h0000_0000: return 8'h33;
      32'h0000_0001: return 8'h44;
      default:       return a[7:0] ^ 8'hA5;
    endcase
  endfunction

  // Byte RAM: registered read, held by the arbiter while rdy_in is low.
  always @(posedge clk_in or negedge rst_in) begin
    if (!rst_in)     mem_din <= 8'h00;
    else if (rdy_in) mem_din <= ram_byte(mem_a);
  end

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  // Present a request in the current cycle T; returns in cycle T+1.
  task automatic req(input logic [31:0] addr);
    data_get_en   = 1'b1;
    data_get_addr = addr;
    tick();
    data_get_en   = 1'b0;
    data_get_addr = 32'hDEAD_BEEF;  // must be ignored during FETCH
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_in        = 1'b0;
    rdy_in        = 1'b1;
    clear         = 1'b0;
    data_get_en   = 1'b0;
    data_get_addr = '0;
    mem_grant     = 1'b1;

    // ---- reset state
    #12;
    check("rst data_en_o", 32'(data_en_o), 32'd0);
    check("rst data_o",    data_o,         32'd0);
    check("rst mem_a",     mem_a,          32'd0);
    check("rst if_busy",   32'(if_busy),   32'd0);
    rst_in = 1'b1;
    tick();
    check("idle if_busy", 32'(if_busy), 32'd0);

    // ---- basic read of 0x100
    req(32'h100);                                        // T+1
    for (int k = 0; k < 4; k++) begin                    // T+1..T+4
      check("basic mem_a",     mem_a,          32'h100 + 32'(k));
      check("basic busy",      32'(if_busy),   32'd1);
      check("basic no pulse",  32'(data_en_o), 32'd0);
      if (k < 3) tick();
    end
    tick();                                              // T+5
    check("basic T+5 pulse", 32'(data_en_o), 32'd0);
    tick();                                              // T+6
    check("basic T+6 pulse", 32'(data_en_o), 32'd1);
    check("basic word",      data_o,         32'h0010_0513);
    tick();                                              // T+7
    check("basic T+7 pulse", 32'(data_en_o), 32'd0);
    check("basic T+7 idle",  32'(if_busy),   32'd0);

    // ---- asynchronous reset in cycle 3 of a fetch
    req(32'h200);                                        // T+1
    tick();                                              // T+2
    tick();                                              // T+3
    #2;
    rst_in = 1'b0;
    #1;
    check("amid data_o",    data_o,         32'd0);
    check("amid mem_a",     mem_a,          32'd0);
    check("amid if_busy",   32'(if_busy),   32'd0);
    check("amid data_en_o", 32'(data_en_o), 32'd0);
    tick();
    rst_in = 1'b1;
    tick();
    check("post-reset idle", 32'(if_busy), 32'd0);

    // ---- grant stall in T+2 and T+3
    req(32'h100);                                        // T+1
    check("stall T+1 mem_a", mem_a, 32'h100);
    tick();                                              // T+2
    mem_grant = 1'b0;
    check("stall T+2 mem_a", mem_a, 32'h101);
    tick();                                              // T+3
    check("stall T+3 mem_a", mem_a, 32'h101);
    tick();                                              // T+4
    mem_grant = 1'b1;
    check("stall T+4 mem_a", mem_a, 32'h101);
    tick();                                              // T+5
    check("stall T+5 mem_a", mem_a, 32'h102);
    tick();                                              // T+6
    check("stall T+6 mem_a", mem_a, 32'h103);
    check("stall T+6 pulse", 32'(data_en_o), 32'd0);
    tick();                                              // T+7
    check("stall T+7 pulse", 32'(data_en_o), 32'd0);
    tick();                                              // T+8
    check("stall T+8 pulse", 32'(data_en_o), 32'd1);
    check("stall word",      data_o,         32'h0010_0513);
    tick();                                              // T+9
    check("stall T+9 idle",  32'(if_busy),   32'd0);

    // ---- flush in T+3, then a new request to 0x200 in T+4
    req(32'h100);                                        // T+1
    tick();                                              // T+2
    tick();                                              // T+3
    clear = 1'b1;
    #1;
    check("flush T+3 pulse", 32'(data_en_o), 32'd0);
    tick();                                              // T+4
    clear = 1'b0;
    check("flush T+4 idle",  32'(if_busy), 32'd0);
    check("flush keeps word", data_o,      32'h0010_0513);
    req(32'h200);                                        // T'+1
    for (int k = 1; k <= 5; k++) begin
      check("flush2 no pulse", 32'(data_en_o), 32'd0);
      tick();
    end                                                  // T'+6
    check("flush2 pulse", 32'(data_en_o), 32'd1);
    check("flush2 word",  data_o,         32'hDDCC_BBAA);
    tick();

    // ---- clear during DONE suppresses the pulse
    req(32'h100);                                        // T+1
    for (int k = 1; k <= 5; k++) tick();                 // T+6
    clear = 1'b1;
    #1;
    check("cdone pulse", 32'(data_en_o), 32'd0);
    check("cdone busy",  32'(if_busy),   32'd1);
    tick();                                              // T+7
    clear = 1'b0;
    check("cdone T+7 idle",  32'(if_busy),   32'd0);
    check("cdone T+7 pulse", 32'(data_en_o), 32'd0);
    check("cdone word",      data_o,         32'h0010_0513);

    // ---- address wrap with rdy_in low in T+3 and T+4
    req(32'hFFFF_FFFE);                                  // T+1
    check("wrap T+1 mem_a", mem_a, 32'hFFFF_FFFE);
    tick();                                              // T+2
    check("wrap T+2 mem_a", mem_a, 32'hFFFF_FFFF);
    tick();                                              // T+3
    rdy_in = 1'b0;
    check("wrap T+3 mem_a", mem_a, 32'h0000_0000);
    tick();                                              // T+4
    check("wrap T+4 mem_a", mem_a, 32'h0000_0000);
    check("wrap T+4 busy",  32'(if_busy), 32'd1);
    tick();                                              // T+5
    rdy_in = 1'b1;
    check("wrap T+5 mem_a", mem_a, 32'h0000_0000);
    tick();                                              // T+6
    check("wrap T+6 mem_a", mem_a, 32'h0000_0001);
    check("wrap T+6 pulse", 32'(data_en_o), 32'd0);
    tick();                                              // T+7
    check("wrap T+7 pulse", 32'(data_en_o), 32'd0);
    tick();                                              // T+8
    check("wrap T+8 pulse", 32'(data_en_o), 32'd1);
    check("wrap word",      data_o,         32'h4433_2211);
    tick();                                              // T+9
    check("wrap T+9 idle",  32'(if_busy),   32'd0);
    check("wrap T+9 pulse", 32'(data_en_o), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
